adc_snap_ctrl: RTL and testbench
================================

Name: adc_snap_ctrl

Overview:
Capture sequencer for the 4x I/Q ADC datapath, running in the ADC clock domain.
- Software arms it and selects a trigger source.
- After an optional post-trigger delay, it writes a fixed-length burst of packed samples into a simple-dual-port BRAM.
- It reports busy, done and the fill level back to the register bus.
- It sits between the ADC interface outputs (8 x 12-bit samples per clock plus the sync pulse) and the snapshot BRAM.

Parameters:
ADDR_W, 10, BRAM address width; max burst = 2^ADDR_W words
DATA_W, 96, packed sample word width: {q3,q2,q1,q0,i3,i2,i1,i0}, 12 bits each
DELAY_W, 16, width of the post-trigger delay counter

Ports:
adc_clk  in  1  ADC domain clock; all logic on the rising edge
adc_rst_n  in  1  reset, asynchronous assert, active-low
ctrl_arm  in  1  single-cycle arm pulse; restarts the sequence from any state
ctrl_trig  in  1  single-cycle software trigger pulse
ctrl_trig_sel  in  2  trigger source: 0 immediate, 1 user_sync rising edge, 2 ext_trig high, 3 ctrl_trig
ctrl_delay  in  DELAY_W  post-trigger wait in cycles
ctrl_len  in  ADDR_W  words to capture; 0 means 2^ADDR_W
din  in  DATA_W  packed sample word, valid every cycle
user_sync  in  1  sync level from the ADC interface
ext_trig  in  1  external trigger, already synchronised to adc_clk
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM write address
bram_din  out  DATA_W  BRAM write data
status_busy  out  1  high in ARMED, DELAY or CAPTURE
status_done  out  1  burst complete; sticky until next arm
status_count  out  ADDR_W+1  words written in the current or last burst

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE; internal registers (sync_d, counters, latched config) are 0.

Arm:
- On ctrl_arm (any state), latch ctrl_trig_sel, ctrl_delay and ctrl_len (len 0 maps to 2^ADDR_W).
- Clear status_done and status_count; go to ARMED next cycle.

State machine IDLE / ARMED / DELAY / CAPTURE / DONE:
- ARMED: evaluate the trigger each cycle.
  - sel 0: fires on the first ARMED cycle.
  - sel 1: fires on user_sync & ~sync_d.
  - sel 2: fires on ext_trig.
  - sel 3: fires on ctrl_trig.
  - On fire: go to DELAY if delay > 0, else CAPTURE.
- DELAY: count down the latched delay.
  - Go to CAPTURE on the cycle the counter reaches 1.
  - Exactly delay cycles are spent in DELAY.
- CAPTURE:
  - Each cycle, register din into bram_din and assert bram_we with bram_addr = status_count.
  - Increment status_count.
  - After writing word len-1: go to DONE, assert status_done, drop bram_we.
- DONE: hold status until ctrl_arm.
- IDLE is reached only from reset.

Timing and data rules:
- Latency from din to bram_din is exactly 1 cycle.
- The first captured word is the din present in the last DELAY cycle (or the trigger cycle when delay = 0).
- bram_addr never wraps inside a burst. len = 2^ADDR_W writes addresses 0..2^ADDR_W-1; status_count ends at 2^ADDR_W.
- Triggers outside ARMED are ignored.
- sync_d updates every cycle regardless of state, so an edge is never double-counted.

Simultaneous events:
- ctrl_arm has priority over trigger and completion in the same cycle.
- An arm during CAPTURE aborts the burst: bram_we drops next cycle and status_count clears.

Optional Feature:
Macro ADC_SNAP_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps at 2^32).
  - Adds an output port status_ts [31:0], latched with the counter value on the trigger-fire cycle; reset value 0; holds until the next trigger.
- Undefined: no counter and no status_ts port; behaviour otherwise identical.

Decomposition:
- Shared package adc_snap_pkg:
  - state enum (IDLE, ARMED, DELAY, CAPTURE, DONE);
  - trigger-select constants TRIG_IMM, TRIG_SYNC, TRIG_EXT, TRIG_SW;
  - sample width constant 12 and lanes-per-clock constant 4.
- One sub-module: adc_snap_trig. It contains the sync edge detect and the source mux, and produces a single-cycle trig_fire qualified by ARMED.

Test Plan:
- Immediate, no delay: sel 0, delay 0, len 4, din = incrementing counter. Required: 4 writes at addr 0..3 carrying consecutive counter values; status_done = 1; status_count = 4; busy low one cycle after the last write.
- Sync trigger: sel 1, delay 10, len 8, user_sync held high before arm then pulsed at t = 50. Required: no capture from the held level; the first write occurs at t = 61 with din sampled at t = 60.
- Full depth: len 0, ADDR_W = 10. Required: 1024 writes at addr 0..1023, no wrap; status_count = 1024.
- Abort and re-arm: ctrl_arm at the 3rd CAPTURE cycle. Required: bram_we low next cycle, status_count = 0, state ARMED; the new burst restarts at addr 0.
- Ignored triggers: ctrl_trig pulses while IDLE and while DONE. Required: no bram_we; status unchanged.
- ADC_SNAP_TIMESTAMP_EN defined: trigger at cycle 1000 after reset. Required: status_ts = 1000 (cycle count after reset deassertion), held through the next arm until the next trigger.

Source files
------------

// File: rtl/adc_snap_pkg.sv
// Shared types and constants for the ADC snapshot capture sequencer.
package adc_snap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        CAPTURE,
        DONE
    } snap_state_t;

    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_SYNC = 2'd1;
    localparam logic [1:0] TRIG_EXT  = 2'd2;
    localparam logic [1:0] TRIG_SW   = 2'd3;

    localparam int SAMPLE_W = 12;
    localparam int LANES    = 4;

    function automatic logic is_busy(snap_state_t s);
        return (s == ARMED) || (s == DELAY) || (s == CAPTURE);
    endfunction

endpackage

// File: rtl/adc_snap_ctrl_if.sv
// Snapshot BRAM write port: the sequencer drives it, the BRAM wrapper consumes it.
interface adc_snap_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 96
);
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;

    modport master (
        output bram_we,
        output bram_addr,
        output bram_din
    );

    modport slave (
        input bram_we,
        input bram_addr,
        input bram_din
    );
endinterface

// File: rtl/adc_snap_trig.sv
// Trigger source selection with user_sync rising-edge detect; fires only while ARMED.
module adc_snap_trig
    import adc_snap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       armed,
    input  logic [1:0] trig_sel,
    input  logic       user_sync,
    input  logic       ext_trig,
    input  logic       ctrl_trig,
    output logic       trig_fire
);

    logic sync_d_reg;
    logic src_hit;

    // Tracks user_sync in every state so a level held across arm is never seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d_reg <= 1'b0;
        end else begin
            sync_d_reg <= user_sync;
        end
    end

    always_comb begin
        src_hit = 1'b0;
        case (trig_sel)
            TRIG_IMM:  src_hit = 1'b1;
            TRIG_SYNC: src_hit = user_sync & ~sync_d_reg;
            TRIG_EXT:  src_hit = ext_trig;
            TRIG_SW:   src_hit = ctrl_trig;
            default:   src_hit = 1'b0;
        endcase
    end

    assign trig_fire = armed & src_hit;

endmodule

// File: rtl/adc_snap_ctrl.sv
// ADC snapshot capture sequencer: arm, trigger, optional delay, fixed-length burst into BRAM.
// Optional ADC_SNAP_TIMESTAMP_EN adds a free-running cycle counter and status_ts trigger stamp.
module adc_snap_ctrl
    import adc_snap_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 96,
    parameter int DELAY_W = 16
) (
    input  logic               adc_clk,
    input  logic               adc_rst_n,
    input  logic               ctrl_arm,
    input  logic               ctrl_trig,
    input  logic [1:0]         ctrl_trig_sel,
    input  logic [DELAY_W-1:0] ctrl_delay,
    input  logic [ADDR_W-1:0]  ctrl_len,
    input  logic [DATA_W-1:0]  din,
    input  logic               user_sync,
    input  logic               ext_trig,
    adc_snap_ctrl_if.master    bram,
    output logic               status_busy,
    output logic               status_done,
    output logic [ADDR_W:0]    status_count
`ifdef ADC_SNAP_TIMESTAMP_EN
    ,
    output logic [31:0]        status_ts
`endif
);

    localparam int NUM_LANES = DATA_W / SAMPLE_W;
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    snap_state_t        state_reg, state_next;
    logic [1:0]         sel_reg;
    logic [DELAY_W-1:0] delay_reg;
    logic [ADDR_W:0]    len_reg;
    logic [DELAY_W-1:0] dly_cnt_reg, dly_cnt_next;
    logic [ADDR_W:0]    count_reg, count_next;
    logic               done_reg, done_next;
    logic               we_reg, we_next;
    logic               load_din;
    logic               trig_fire;
    logic [SAMPLE_W-1:0] lane_reg [NUM_LANES];

    adc_snap_trig u_trig (
        .clk       (adc_clk),
        .rst_n     (adc_rst_n),
        .armed     (state_reg == ARMED),
        .trig_sel  (sel_reg),
        .user_sync (user_sync),
        .ext_trig  (ext_trig),
        .ctrl_trig (ctrl_trig),
        .trig_fire (trig_fire)
    );

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            sel_reg   <= '0;
            delay_reg <= '0;
            len_reg   <= '0;
        end else if (ctrl_arm) begin
            sel_reg   <= ctrl_trig_sel;
            delay_reg <= ctrl_delay;
            len_reg   <= (ctrl_len == '0) ? LEN_MAX : {1'b0, ctrl_len};
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state_reg   <= IDLE;
            dly_cnt_reg <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            we_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dly_cnt_reg <= dly_cnt_next;
            count_reg   <= count_next;
            done_reg    <= done_next;
            we_reg      <= we_next;
        end
    end

    // Entering CAPTURE already loads the first word, so bram_we is high on every CAPTURE cycle.
    always_comb begin
        state_next   = state_reg;
        dly_cnt_next = dly_cnt_reg;
        count_next   = count_reg;
        done_next    = done_reg;
        we_next      = 1'b0;
        load_din     = 1'b0;
        if (ctrl_arm) begin
            state_next = ARMED;
            count_next = '0;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (trig_fire) begin
                        if (delay_reg != '0) begin
                            state_next   = DELAY;
                            dly_cnt_next = delay_reg;
                        end else begin
                            state_next = CAPTURE;
                            we_next    = 1'b1;
                            load_din   = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt_reg == DELAY_W'(1)) begin
                        state_next   = CAPTURE;
                        dly_cnt_next = '0;
                        we_next      = 1'b1;
                        load_din     = 1'b1;
                    end else begin
                        dly_cnt_next = dly_cnt_reg - 1'b1;
                    end
                end
                CAPTURE: begin
                    count_next = count_reg + 1'b1;
                    if (count_reg == len_reg - 1'b1) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        we_next  = 1'b1;
                        load_din = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge adc_clk or negedge adc_rst_n) begin
                if (!adc_rst_n) begin
                    lane_reg[gi] <= '0;
                end else if (load_din) begin
                    lane_reg[gi] <= din[gi*SAMPLE_W +: SAMPLE_W];
                end
            end
            assign bram.bram_din[gi*SAMPLE_W +: SAMPLE_W] = lane_reg[gi];
        end
    endgenerate

    assign bram.bram_we   = we_reg;
    assign bram.bram_addr = count_reg[ADDR_W-1:0];
    assign status_busy    = is_busy(state_reg);
    assign status_done    = done_reg;
    assign status_count   = count_reg;

`ifdef ADC_SNAP_TIMESTAMP_EN
    logic [31:0] ts_cnt_reg;
    logic [31:0] ts_reg;

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            ts_cnt_reg <= '0;
            ts_reg     <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 32'd1;
            if (trig_fire && !ctrl_arm) begin
                ts_reg <= ts_cnt_reg;
            end
        end
    end

    assign status_ts = ts_reg;
`endif

endmodule

// File: tb/tb_adc_snap_ctrl.sv
// Directed bench for adc_snap_ctrl: vector table of bursts plus hand-written corner sequences.
module tb_adc_snap_ctrl;
    import adc_snap_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 96;
    localparam int DELAY_W = 16;

    logic               adc_clk = 1'b0;
    logic               adc_rst_n = 1'b0;
    logic               ctrl_arm = 1'b0;
    logic               ctrl_trig = 1'b0;
    logic [1:0]         ctrl_trig_sel = '0;
    logic [DELAY_W-1:0] ctrl_delay = '0;
    logic [ADDR_W-1:0]  ctrl_len = '0;
    logic [DATA_W-1:0]  din = '0;
    logic               user_sync = 1'b0;
    logic               ext_trig = 1'b0;
    logic               status_busy;
    logic               status_done;
    logic [ADDR_W:0]    status_count;
`ifdef ADC_SNAP_TIMESTAMP_EN
    logic [31:0]        status_ts;
    int unsigned        cyc = 0;
    always @(posedge adc_clk) if (adc_rst_n) cyc <= cyc + 1;
`endif

    adc_snap_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bram_bus ();

    adc_snap_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DELAY_W(DELAY_W)) dut (
        .adc_clk       (adc_clk),
        .adc_rst_n     (adc_rst_n),
        .ctrl_arm      (ctrl_arm),
        .ctrl_trig     (ctrl_trig),
        .ctrl_trig_sel (ctrl_trig_sel),
        .ctrl_delay    (ctrl_delay),
        .ctrl_len      (ctrl_len),
        .din           (din),
        .user_sync     (user_sync),
        .ext_trig      (ext_trig),
        .bram          (bram_bus),
        .status_busy   (status_busy),
        .status_done   (status_done),
        .status_count  (status_count)
`ifdef ADC_SNAP_TIMESTAMP_EN
        ,
        .status_ts     (status_ts)
`endif
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic [1:0] sel;
        int         delay;
        int         len;
        int         trig_off;
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int passes = 0;
    int vcnt = 0;
    int cur_v = 0;
    int wr_seen = 0;
    int last_wr_v = -1;
    int exp_first = 0;
    bit exp_wr_en = 1'b0;

    function automatic logic [DATA_W-1:0] pat(int v);
        logic [31:0] u;
        u = v;
        return {u, ~u, u * 32'h9E37_79B9};
    endfunction

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cur_v);
    endtask

    // One clock: observe the cycle just started, then drive that cycle's inputs.
    task automatic tick();
        @(posedge adc_clk);
        #1;
        if (bram_bus.bram_we) begin
            if (exp_wr_en) begin
                check("wr_addr", bram_bus.bram_addr, wr_seen);
                check("wr_data", bram_bus.bram_din, pat(exp_first + wr_seen));
                check("wr_latency", bram_bus.bram_din, pat(vcnt - 1));
            end
            wr_seen++;
            last_wr_v = vcnt;
        end
        ctrl_arm  = 1'b0;
        ctrl_trig = 1'b0;
        ext_trig  = 1'b0;
        din   = pat(vcnt);
        cur_v = vcnt;
        vcnt++;
    endtask

    task automatic arm(logic [1:0] sel, int delay, int len, int trig_off);
        ctrl_arm      = 1'b1;
        ctrl_trig_sel = sel;
        ctrl_delay    = DELAY_W'(delay);
        ctrl_len      = ADDR_W'(len);
        exp_first     = cur_v + 1 + trig_off + delay;
        wr_seen       = 0;
        last_wr_v     = -1;
        exp_wr_en     = 1'b1;
    endtask

    task automatic finish_burst(int len_eff);
        int n;
        n = 0;
        while (!status_done && n < 3000) begin
            tick();
            n++;
        end
        check("done_in_time", n < 3000, 1);
        check("burst_writes", wr_seen, len_eff);
        check("burst_count", status_count, len_eff);
        check("busy_after", status_busy, 0);
        check("we_after", bram_bus.bram_we, 0);
        check("last_wr_timing", last_wr_v, cur_v - 1);
        $display("burst len=%0d writes=%0d count=%0d done=%0d", len_eff, wr_seen, status_count, status_done);
    endtask

    task automatic run_vec(vec_t v);
        tick();
        arm(v.sel, v.delay, v.len, v.trig_off);
        for (int i = 0; i <= v.trig_off; i++) tick();
        if (v.trig_off > 0) begin
            check("armed_busy", status_busy, 1);
            check("armed_nowr", wr_seen, 0);
        end
        case (v.sel)
            TRIG_SYNC: user_sync = 1'b1;
            TRIG_EXT:  ext_trig  = 1'b1;
            TRIG_SW:   ctrl_trig = 1'b1;
            default: ;
        endcase
        tick();
        user_sync = 1'b0;
        finish_burst((v.len == 0 || v.len == 1024) ? 1024 : v.len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_hold;
        int wr_hold;
        int n;
        vecs[0] = '{TRIG_IMM,  0, 4,    0};
        vecs[1] = '{TRIG_IMM,  3, 5,    0};
        vecs[2] = '{TRIG_EXT,  0, 3,    4};
        vecs[3] = '{TRIG_SW,   2, 6,    2};
        vecs[4] = '{TRIG_SYNC, 1, 2,    3};
        vecs[5] = '{TRIG_IMM,  0, 1024, 0};
        vecs[6] = '{TRIG_IMM,  0, 1,    0};
        vecs[7] = '{TRIG_SW,   1, 1,    0};

        #22 adc_rst_n = 1'b1;
        tick();
        check("rst_we", bram_bus.bram_we, 0);
        check("rst_addr", bram_bus.bram_addr, 0);
        check("rst_din", bram_bus.bram_din, 0);
        check("rst_busy", status_busy, 0);
        check("rst_done", status_done, 0);
        check("rst_count", status_count, 0);

        // Triggers while IDLE must do nothing.
        ctrl_trig_sel = TRIG_SW;
        ctrl_trig = 1'b1;
        ext_trig  = 1'b1;
        user_sync = 1'b1;
        tick();
        user_sync = 1'b0;
        repeat (4) tick();
        check("idle_nowr", wr_seen, 0);
        check("idle_busy", status_busy, 0);
        check("idle_done", status_done, 0);
        $display("idle triggers: writes=%0d busy=%0d", wr_seen, status_busy);

        for (int i = 0; i < 8; i++) begin
            $display("vector %0d sel=%0d delay=%0d len=%0d", i, vecs[i].sel, vecs[i].delay, vecs[i].len);
            run_vec(vecs[i]);
        end

        // Triggers while DONE must leave status unchanged.
        cnt_hold  = status_count;
        wr_hold   = wr_seen;
        exp_wr_en = 1'b0;
        tick();
        ctrl_trig = 1'b1;
        ext_trig  = 1'b1;
        user_sync = 1'b1;
        tick();
        user_sync = 1'b0;
        repeat (4) tick();
        check("done_hold", status_done, 1);
        check("done_count", status_count, cnt_hold);
        check("done_nowr", wr_seen, wr_hold);
        check("done_busy", status_busy, 0);
        $display("done triggers: done=%0d count=%0d", status_done, status_count);

        // Sync held high across arm: only a fresh rising edge fires.
        user_sync = 1'b1;
        tick();
        tick();
        arm(TRIG_SYNC, 10, 8, 0);
        repeat (6) tick();
        check("sync_held_busy", status_busy, 1);
        check("sync_held_nowr", wr_seen, 0);
        user_sync = 1'b0;
        tick();
        user_sync = 1'b1;
        exp_first = cur_v + 10;
        repeat (5) tick();
        check("sync_delay_busy", status_busy, 1);
        check("sync_delay_nowr", wr_seen, 0);
        finish_burst(8);
        user_sync = 1'b0;

        // Arm during the third CAPTURE cycle aborts and restarts.
        tick();
        arm(TRIG_IMM, 0, 8, 0);
        n = 0;
        tick();
        while (!(bram_bus.bram_we && bram_bus.bram_addr == 2) && n < 50) begin
            tick();
            n++;
        end
        check("abort_reach", n < 50, 1);
        arm(TRIG_IMM, 0, 3, 0);
        tick();
        check("abort_we", bram_bus.bram_we, 0);
        check("abort_count", status_count, 0);
        check("abort_busy", status_busy, 1);
        check("abort_done", status_done, 0);
        $display("abort: we=%0d count=%0d busy=%0d", bram_bus.bram_we, status_count, status_busy);
        finish_burst(3);

`ifdef ADC_SNAP_TIMESTAMP_EN
        begin
            int unsigned exp_ts;
            tick();
            arm(TRIG_SW, 0, 2, 2);
            repeat (3) tick();
            ctrl_trig = 1'b1;
            exp_ts = cyc;
            tick();
            check("ts_latch", status_ts, exp_ts);
            finish_burst(2);
            tick();
            arm(TRIG_SW, 0, 2, 0);
            repeat (3) tick();
            check("ts_hold", status_ts, exp_ts);
            $display("timestamp: ts=%0d expected=%0d", status_ts, exp_ts);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
